jtag_dtm_sync: RTL and testbench
================================

JTAG_DTM_SYNC -- requirements
Module: jtag_dtm_sync

Interface
REQ-001 SHALL have parameter DMI_ADDR_BITS, default 6, DMI address width.
REQ-002 SHALL have parameter DMI_DATA_BITS, default 32, DMI data width.
REQ-003 SHALL have parameter DMI_OP_BITS, default 2, DMI op/status width; DMI_BITS = sum of the three (40 at defaults).
REQ-004 SHALL have parameter IDCODE_VAL, default 32'h1E200A6D, value captured by IDCODE.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 jtag_tck_i  input  1  JTAG TCK, asynchronous, oversampled on clk.
REQ-008 jtag_tms_i  input  1  JTAG TMS, asynchronous.
REQ-009 jtag_tdi_i  input  1  JTAG TDI, asynchronous.
REQ-010 jtag_tdo_o  output  1  JTAG TDO, registered.
REQ-011 dtm_req_valid_o  output  1  4-phase request to DM.
REQ-012 dtm_req_data_o  output  DMI_BITS  {addr, data, op}, stable while dtm_req_valid_o high.
REQ-013 dm_ack_i  input  1  DM request acknowledge.
REQ-014 dm_resp_valid_i  input  1  DM response request.
REQ-015 dm_resp_data_i  input  DMI_BITS  {addr, data, status}.
REQ-016 dtm_ack_o  output  1  response acknowledge to DM.

Function
REQ-017 tck/tms/tdi SHALL pass 2-flop synchronizers; TCK rise = sync tck 0->1, TCK fall = 1->0, one clk pulse each.
REQ-018 16-state IEEE 1149.1 TAP FSM SHALL advance only on TCK rise using synced TMS; 5 TMS=1 rises from any state reach Test-Logic-Reset.
REQ-019 IR 5 bits: IDCODE=5'h01, DTMCS=5'h10, DMI=5'h11, BYPASS=5'h1F, any other code acts as BYPASS; Test-Logic-Reset loads IDCODE.
REQ-020 Capture-IR loads 5'b00001; Shift-IR/DR shift LSB first, TDI into MSB, on TCK rise.
REQ-021 jtag_tdo_o SHALL update on TCK fall with shift register LSB in Shift-IR/Shift-DR, else hold 0.
REQ-022 DTMCS capture: [3:0]=1 (version), [9:4]=DMI_ADDR_BITS, [11:10]=dmistat, [14:12]=3'd5 (idle), others 0.
REQ-023 DTMCS Update-DR: bit16 (dmireset) clears dmistat; bit17 (dmihardreset) clears dmistat and abandons any pending transaction, dropping request and ack to 0 next clk.
REQ-024 DMI capture: {last response addr, last response data, status}; status = 2'b11 if busy or dmistat!=0, else 2'b00.
REQ-025 DMI Update-DR with op!=0, not busy, dmistat==0: latch shift register into dtm_req_data_o, assert dtm_req_valid_o next clk, set busy.
REQ-026 DMI Update-DR while busy SHALL set dmistat=2'b11 (sticky) and issue nothing; op==0 issues nothing.
REQ-027 Request FSM states REQ_IDLE, REQ_WAIT_ACK, REQ_WAIT_ACKLOW, RSP_WAIT: valid held until dm_ack_i=1, then dropped; then wait dm_ack_i=0; then RSP_WAIT.
REQ-028 dm_resp_valid_i=1 (any state) SHALL capture dm_resp_data_i, assert dtm_ack_o next clk, hold until dm_resp_valid_i=0, then drop; busy clears when dtm_ack_o falls and request FSM is in RSP_WAIT or REQ_IDLE.
REQ-029 Response arriving before dm_ack_i falls SHALL be captured; busy clears only after both handshakes complete.
REQ-030 Simultaneous TCK rise and dm_resp_valid_i SHALL both be processed in the same clk.

Reset
REQ-031 rst_n low: TAP=Test-Logic-Reset, IR=IDCODE, shift reg=0, jtag_tdo_o=0, dtm_req_valid_o=0, dtm_req_data_o=0, dtm_ack_o=0, busy=0, dmistat=0, response latch=0, synchronizers=0.
REQ-032 Reset mid-transaction SHALL abandon it without further outputs.

Configuration
REQ-033 Macro JTAG_DTM_IDCODE_EN defined: IDCODE instruction captures IDCODE_VAL (32-bit DR).
REQ-034 Macro undefined: IDCODE code behaves as BYPASS (1-bit DR, captures 0); reset IR still 5'h01.

Verification
REQ-035 Reset, shift IR 5'h01, 32-bit DR scan (macro on) -> TDO yields 32'h1E200A6D LSB first.
REQ-036 IR 5'h10, DR scan zeros -> 32'h00005061 out.
REQ-037 DMI write {6'h04,32'hDEADBEEF,2'b10} -> dtm_req_data_o=40'h137AB6FBBE, valid held until ack, full 4-phase completes.
REQ-038 Second DMI update while DM withholds ack -> no new request, DTMCS [11:10]=3, next DMI capture status=3; dmireset clears.
REQ-039 DM returns {6'h11,32'h00430C82,2'b00} -> next DMI capture shifts out 40'h44010C3208.
REQ-040 dmihardreset during REQ_WAIT_ACK -> dtm_req_valid_o=0 next clk, busy=0.

Source files
------------

// File: rtl/jtag_dtm_sync.sv
// JTAG debug transport module: TAP oversampled on clk, IDCODE/DTMCS/DMI/BYPASS registers, 4-phase DMI handshake.
// Define JTAG_DTM_IDCODE_EN to give IDCODE its 32-bit register; otherwise the IDCODE code behaves as BYPASS.
module jtag_dtm_sync #(
    parameter int          DMI_ADDR_BITS = 6,
    parameter int          DMI_DATA_BITS = 32,
    parameter int          DMI_OP_BITS   = 2,
    parameter logic [31:0] IDCODE_VAL    = 32'h1E200A6D,
    localparam int         DMI_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jtag_tck_i,
    input  logic                jtag_tms_i,
    input  logic                jtag_tdi_i,
    output logic                jtag_tdo_o,
    output logic                dtm_req_valid_o,
    output logic [DMI_BITS-1:0] dtm_req_data_o,
    input  logic                dm_ack_i,
    input  logic                dm_resp_valid_i,
    input  logic [DMI_BITS-1:0] dm_resp_data_i,
    output logic                dtm_ack_o
);

    localparam int         SR_W      = (DMI_BITS > 32) ? DMI_BITS : 32;
    localparam int         RSP_W     = DMI_BITS - DMI_OP_BITS;
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TAP_RESET, TAP_IDLE,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE, REQ_WAIT_ACK, REQ_WAIT_ACKLOW, RSP_WAIT
    } req_state_e;

    logic                r_tck_s1, r_tck_s2, r_tck_d;
    logic                r_tms_s1, r_tms_s2;
    logic                r_tdi_s1, r_tdi_s2;
    tap_state_e          r_tap, w_tap_next;
    req_state_e          r_req_state, w_req_next;
    logic [4:0]          r_ir;
    logic [SR_W-1:0]     r_sr;
    logic                r_tdo;
    logic [1:0]          r_dmistat;
    logic [DMI_BITS-1:0] r_req_data;
    logic                r_ack;
    logic [RSP_W-1:0]    r_rsp;
    logic                r_rsp_done;

    logic                w_tck_rise, w_tck_fall;
    logic                w_busy;
    logic [31:0]         w_dtmcs;
    logic [DMI_OP_BITS-1:0] w_dmi_status;
    logic [SR_W-1:0]     w_dr_cap;
    int                  w_dr_len;
    int                  w_len;
    logic [SR_W-1:0]     w_sr_shift;
    logic                w_upd_dr;
    logic                w_dtmcs_upd, w_dmireset, w_hardreset;
    logic                w_dmi_upd, w_issue, w_busy_err;
    logic                w_ack_fall, w_rsp_complete;
    logic                w_unused_rsp_status;

    assign w_tck_rise = r_tck_s2 & ~r_tck_d;
    assign w_tck_fall = ~r_tck_s2 & r_tck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tck_s1 <= 1'b0;
            r_tck_s2 <= 1'b0;
            r_tck_d  <= 1'b0;
            r_tms_s1 <= 1'b0;
            r_tms_s2 <= 1'b0;
            r_tdi_s1 <= 1'b0;
            r_tdi_s2 <= 1'b0;
        end else begin
            r_tck_s1 <= jtag_tck_i;
            r_tck_s2 <= r_tck_s1;
            r_tck_d  <= r_tck_s2;
            r_tms_s1 <= jtag_tms_i;
            r_tms_s2 <= r_tms_s1;
            r_tdi_s1 <= jtag_tdi_i;
            r_tdi_s2 <= r_tdi_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tap <= TAP_RESET;
        else        r_tap <= w_tap_next;
    end

    always_comb begin
        w_tap_next = r_tap;
        if (w_tck_rise) begin
            case (r_tap)
                TAP_RESET:  w_tap_next = r_tms_s2 ? TAP_RESET  : TAP_IDLE;
                TAP_IDLE:   w_tap_next = r_tms_s2 ? TAP_SEL_DR : TAP_IDLE;
                TAP_SEL_DR: w_tap_next = r_tms_s2 ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR: w_tap_next = r_tms_s2 ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:  w_tap_next = r_tms_s2 ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR: w_tap_next = r_tms_s2 ? TAP_UPD_DR : TAP_PAU_DR;
                TAP_PAU_DR: w_tap_next = r_tms_s2 ? TAP_EX2_DR : TAP_PAU_DR;
                TAP_EX2_DR: w_tap_next = r_tms_s2 ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR: w_tap_next = r_tms_s2 ? TAP_SEL_DR : TAP_IDLE;
                TAP_SEL_IR: w_tap_next = r_tms_s2 ? TAP_RESET  : TAP_CAP_IR;
                TAP_CAP_IR: w_tap_next = r_tms_s2 ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:  w_tap_next = r_tms_s2 ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR: w_tap_next = r_tms_s2 ? TAP_UPD_IR : TAP_PAU_IR;
                TAP_PAU_IR: w_tap_next = r_tms_s2 ? TAP_EX2_IR : TAP_PAU_IR;
                TAP_EX2_IR: w_tap_next = r_tms_s2 ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR: w_tap_next = r_tms_s2 ? TAP_SEL_DR : TAP_IDLE;
                default:    w_tap_next = TAP_RESET;
            endcase
        end
    end

    assign w_busy       = (r_req_state != REQ_IDLE);
    assign w_dtmcs      = {17'd0, 3'd5, r_dmistat, 6'(DMI_ADDR_BITS), 4'd1};
    assign w_dmi_status = (w_busy || (r_dmistat != 2'b00)) ? '1 : '0;

    // Unlisted instruction codes fall through to the 1-bit bypass register.
    always_comb begin
        w_dr_len = 1;
        w_dr_cap = '0;
        case (r_ir)
            IR_DTMCS: begin
                w_dr_len = 32;
                w_dr_cap = SR_W'(w_dtmcs);
            end
            IR_DMI: begin
                w_dr_len = DMI_BITS;
                w_dr_cap = SR_W'({r_rsp, w_dmi_status});
            end
`ifdef JTAG_DTM_IDCODE_EN
            IR_IDCODE: begin
                w_dr_len = 32;
                w_dr_cap = SR_W'(IDCODE_VAL);
            end
`endif
            default: ;
        endcase
    end

    // TDI enters at the MSB of whichever register is selected, so the active length matters.
    assign w_len = (r_tap == TAP_SH_IR) ? 5 : w_dr_len;

    always_comb begin
        w_sr_shift = '0;
        for (int i = 0; i < SR_W - 1; i++) begin
            if (i < w_len - 1) w_sr_shift[i] = r_sr[i + 1];
        end
        for (int i = 0; i < SR_W; i++) begin
            if (i == w_len - 1) w_sr_shift[i] = r_tdi_s2;
        end
    end

    assign w_upd_dr    = w_tck_fall && (r_tap == TAP_UPD_DR);
    assign w_dtmcs_upd = w_upd_dr && (r_ir == IR_DTMCS);
    assign w_dmireset  = w_dtmcs_upd && r_sr[16];
    assign w_hardreset = w_dtmcs_upd && r_sr[17];
    assign w_dmi_upd   = w_upd_dr && (r_ir == IR_DMI);
    assign w_busy_err  = w_dmi_upd && w_busy;
    assign w_issue     = w_dmi_upd && !w_busy && (r_sr[DMI_OP_BITS-1:0] != '0) && (r_dmistat == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= IR_IDCODE;
            r_sr       <= '0;
            r_tdo      <= 1'b0;
            r_dmistat  <= 2'b00;
            r_req_data <= '0;
        end else begin
            if (r_tap == TAP_RESET)
                r_ir <= IR_IDCODE;
            else if (w_tck_fall && (r_tap == TAP_UPD_IR))
                r_ir <= r_sr[4:0];

            if (w_tck_rise) begin
                case (r_tap)
                    TAP_CAP_IR:           r_sr <= SR_W'(5'b00001);
                    TAP_CAP_DR:           r_sr <= w_dr_cap;
                    TAP_SH_IR, TAP_SH_DR: r_sr <= w_sr_shift;
                    default: ;
                endcase
            end

            if (w_tck_fall)
                r_tdo <= ((r_tap == TAP_SH_IR) || (r_tap == TAP_SH_DR)) ? r_sr[0] : 1'b0;

            if (w_hardreset || w_dmireset)
                r_dmistat <= 2'b00;
            else if (w_busy_err)
                r_dmistat <= 2'b11;

            if (w_issue)
                r_req_data <= r_sr[DMI_BITS-1:0];
        end
    end

    assign w_ack_fall     = r_ack & ~dm_resp_valid_i;
    assign w_rsp_complete = w_ack_fall | r_rsp_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_req_state <= REQ_IDLE;
        else        r_req_state <= w_req_next;
    end

    always_comb begin
        w_req_next = r_req_state;
        case (r_req_state)
            REQ_IDLE:        if (w_issue)        w_req_next = REQ_WAIT_ACK;
            REQ_WAIT_ACK:    if (dm_ack_i)       w_req_next = REQ_WAIT_ACKLOW;
            REQ_WAIT_ACKLOW: if (!dm_ack_i)      w_req_next = RSP_WAIT;
            RSP_WAIT:        if (w_rsp_complete) w_req_next = REQ_IDLE;
            default:                             w_req_next = REQ_IDLE;
        endcase
        if (w_hardreset) w_req_next = REQ_IDLE;
    end

    // A response may finish before the DM drops its ack; r_rsp_done remembers it until RSP_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_rsp      <= '0;
            r_rsp_done <= 1'b0;
        end else if (w_hardreset) begin
            r_ack      <= 1'b0;
            r_rsp_done <= 1'b0;
        end else begin
            if (dm_resp_valid_i && !r_ack) begin
                r_ack <= 1'b1;
                r_rsp <= dm_resp_data_i[DMI_BITS-1:DMI_OP_BITS];
            end else if (w_ack_fall) begin
                r_ack <= 1'b0;
            end

            if ((r_req_state == RSP_WAIT) && w_rsp_complete)
                r_rsp_done <= 1'b0;
            else if (w_ack_fall && w_busy)
                r_rsp_done <= 1'b1;
        end
    end

    assign w_unused_rsp_status = ^dm_resp_data_i[DMI_OP_BITS-1:0];

    assign jtag_tdo_o      = r_tdo;
    assign dtm_req_valid_o = (r_req_state == REQ_WAIT_ACK);
    assign dtm_req_data_o  = r_req_data;
    assign dtm_ack_o       = r_ack;

endmodule

// File: tb/tb_jtag_dtm_sync.sv
// Randomized bench for jtag_dtm_sync: drives TAP scans and a DM agent, checks against a transaction-level model.
module tb_jtag_dtm_sync;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jtag_tck, jtag_tms, jtag_tdi;
    logic        jtag_tdo;
    logic        dtm_req_valid;
    logic [39:0] dtm_req_data;
    logic        dm_ack, dm_resp_valid;
    logic [39:0] dm_resp_data;
    logic        dtm_ack;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  m_ir;
    logic [1:0]  m_dmistat;
    bit          m_busy;
    bit          m_issued;
    logic [37:0] m_rsp;
    logic [39:0] m_req;

    jtag_dtm_sync dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jtag_tck_i      (jtag_tck),
        .jtag_tms_i      (jtag_tms),
        .jtag_tdi_i      (jtag_tdi),
        .jtag_tdo_o      (jtag_tdo),
        .dtm_req_valid_o (dtm_req_valid),
        .dtm_req_data_o  (dtm_req_data),
        .dm_ack_i        (dm_ack),
        .dm_resp_valid_i (dm_resp_valid),
        .dm_resp_data_i  (dm_resp_data),
        .dtm_ack_o       (dtm_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return (which == 0) ? dtm_req_valid : dtm_ack;
    endfunction

    task automatic wait_sig(input int which, input logic lvl, input string tag);
        logic v;
        v = sig(which);
        for (int n = 0; n < 400 && v !== lvl; n++) begin
            @(negedge clk);
            v = sig(which);
        end
        chk(tag, 64'(v), 64'(lvl));
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        jtag_tms = tms_v;
        jtag_tdi = tdi_v;
        repeat (H) @(negedge clk);
        tdo_v    = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (H) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic d;
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        m_ir = 5'h01;
    endtask

    task automatic scan_dr(input logic [39:0] din, input int len, output logic [39:0] dout);
        logic d, b;
        dout = '0;
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], b);
            dout[i] = b;
        end
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
    endtask

    task automatic scan_ir(input logic [4:0] din);
        logic d, b;
        logic [4:0] dout;
        dout = '0;
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, din[i], b);
            dout[i] = b;
        end
        tck_cycle(1'b1, 1'b0, d);
        tck_cycle(1'b0, 1'b0, d);
        chk("ir_capture", 64'(dout), 64'h01);
        m_ir = din;
    endtask

    function automatic int dr_len();
        case (m_ir)
            5'h10: return 32;
            5'h11: return 40;
`ifdef JTAG_DTM_IDCODE_EN
            5'h01: return 32;
`endif
            default: return 1;
        endcase
    endfunction

    function automatic logic [39:0] exp_cap();
        case (m_ir)
            5'h10: return 40'(32'd1 + 32'd6 * 16 + 32'(m_dmistat) * 1024 + 32'd5 * 4096);
            5'h11: return {m_rsp, (m_busy || m_dmistat != 2'b00) ? 2'b11 : 2'b00};
`ifdef JTAG_DTM_IDCODE_EN
            5'h01: return 40'h1E200A6D;
`endif
            default: return 40'h0;
        endcase
    endfunction

    task automatic do_dr(input string tag, input logic [39:0] din);
        logic [39:0] got, exp;
        int len;
        len = dr_len();
        exp = exp_cap();
        scan_dr(din, len, got);
        chk(tag, 64'(got), 64'(exp));
        m_issued = 0;
        if (m_ir == 5'h10) begin
            if (din[17]) begin
                m_busy    = 0;
                m_dmistat = 2'b00;
            end
            if (din[16]) m_dmistat = 2'b00;
        end else if (m_ir == 5'h11) begin
            if (m_busy) m_dmistat = 2'b11;
            else if (din[1:0] != 2'b00 && m_dmistat == 2'b00) begin
                m_busy   = 1;
                m_issued = 1;
                m_req    = din;
            end
        end
    endtask

    task automatic wait_req(input logic [39:0] exp, input string tag);
        wait_sig(0, 1'b1, {tag, "_vld"});
        chk({tag, "_dat"}, 64'(dtm_req_data), 64'(exp));
    endtask

    task automatic dm_finish(input logic [39:0] rsp, input bit early);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        dm_ack = 1'b1;
        wait_sig(0, 1'b0, "vld_drop");
        if (!early) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            dm_ack = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        dm_resp_data  = rsp;
        dm_resp_valid = 1'b1;
        wait_sig(1, 1'b1, "rsp_ack");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        dm_resp_valid = 1'b0;
        wait_sig(1, 1'b0, "rsp_ack_low");
        if (early) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            dm_ack = 1'b0;
        end
        repeat (4) @(negedge clk);
        m_busy = 0;
        m_rsp  = rsp[39:2];
    endtask

    initial begin
        logic [39:0] w, rsp;
        logic d;
        rst_n = 1'b0;
        jtag_tck = 1'b0; jtag_tms = 1'b0; jtag_tdi = 1'b0;
        dm_ack = 1'b0; dm_resp_valid = 1'b0; dm_resp_data = '0;
        m_ir = 5'h01; m_dmistat = 2'b00; m_busy = 0; m_issued = 0; m_rsp = '0; m_req = '0;
        repeat (5) @(negedge clk);
        chk("rst_tdo", 64'(jtag_tdo), 64'h0);
        chk("rst_vld", 64'(dtm_req_valid), 64'h0);
        chk("rst_dat", 64'(dtm_req_data), 64'h0);
        chk("rst_ack", 64'(dtm_ack), 64'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        tap_reset();
        do_dr("idcode_after_reset", 40'hA5);
        scan_ir(5'h01);
        do_dr("idcode_scan", 40'h0);
        scan_ir(5'h10);
        do_dr("dtmcs_read", 40'h0);

        for (int i = 0; i < 24; i++) tck_cycle(1'($urandom), 1'b0, d);
        tap_reset();
        do_dr("tlr_ir_idcode", 40'hFF);

        scan_ir(5'h11);
        do_dr("dmi_write_cap", 40'h137AB6FBBE);
        wait_req(40'h137AB6FBBE, "dmi_write");
        repeat (10) @(negedge clk);
        chk("vld_held_no_ack", 64'(dtm_req_valid), 64'h1);
        do_dr("dmi_busy_cap", {6'h2A, 32'h12345678, 2'b01});
        chk("busy_no_new_vld", 64'(dtm_req_valid), 64'h1);
        chk("busy_no_new_dat", 64'(dtm_req_data), 64'h137AB6FBBE);
        scan_ir(5'h10);
        do_dr("dtmcs_busy_stat", 40'h0);
        dm_finish({6'h11, 32'h00430C82, 2'b00}, 1'b1);
        do_dr("dtmcs_dmireset", 40'h10000);
        scan_ir(5'h11);
        do_dr("dmi_rsp_cap", 40'h0);
        chk("dmi_rsp_const", 64'({m_rsp, 2'b00}), 64'h44010C3208);

        do_dr("hr_write_cap", {6'($urandom), 32'($urandom), 2'($urandom_range(1, 3))});
        wait_req(m_req, "hr_req");
        scan_ir(5'h10);
        do_dr("hr_dtmcs", 40'h20000);
        chk("hr_vld_low", 64'(dtm_req_valid), 64'h0);
        chk("hr_ack_low", 64'(dtm_ack), 64'h0);
        scan_ir(5'h11);
        do_dr("hr_dmi_status", 40'h0);

        for (int it = 0; it < 8; it++) begin
            w = {6'($urandom), 32'($urandom), 2'($urandom)};
            do_dr("rnd_wr_cap", w);
            if (m_issued) begin
                wait_req(m_req, "rnd_req");
                if ($urandom_range(0, 1) == 1) begin
                    do_dr("rnd_busy_cap", {6'($urandom), 32'($urandom), 2'($urandom)});
                    chk("rnd_vld_held", 64'(dtm_req_valid), 64'h1);
                    chk("rnd_dat_held", 64'(dtm_req_data), 64'(m_req));
                end
                rsp = {6'($urandom), 32'($urandom), 2'($urandom)};
                dm_finish(rsp, 1'($urandom_range(0, 1)));
            end else begin
                repeat (16) @(negedge clk);
                chk("rnd_no_req", 64'(dtm_req_valid), 64'h0);
            end
            if (m_dmistat != 2'b00 && $urandom_range(0, 1) == 1) begin
                scan_ir(5'h10);
                do_dr("rnd_dmireset", 40'h10000);
                scan_ir(5'h11);
            end
        end

        scan_ir(5'h10);
        do_dr("pre_rst_clear", 40'h10000);
        scan_ir(5'h11);
        do_dr("rst_mid_cap", {6'h3F, 32'hCAFEF00D, 2'b10});
        wait_req(40'hFF2BFBC036, "rst_mid_req");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_vld", 64'(dtm_req_valid), 64'h0);
        chk("rst_mid_dat", 64'(dtm_req_data), 64'h0);
        chk("rst_mid_ack", 64'(dtm_ack), 64'h0);
        rst_n = 1'b1;
        m_busy = 0; m_dmistat = 2'b00; m_rsp = '0;
        repeat (3) @(negedge clk);
        tap_reset();
        scan_ir(5'h11);
        do_dr("rst_mid_dmi_cap", 40'h0);
        repeat (20) @(negedge clk);
        chk("rst_mid_quiet", 64'(dtm_req_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
